axi_stream_skid_slice: RTL

AXI_STREAM_SKID_SLICE -- requirements
Module: axi_stream_skid_slice

---
 rtl/axi_stream_skid_slice.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi_stream_skid_slice.sv
// axi_stream_skid_slice: per-lane AXI-Stream register slice with one skid entry.
// Each lane buffers up to two beats.
// s_axis_tready comes straight from a flop.
// m_axis is driven from the lane's main register, so forward latency is one cycle.
// Lanes share only the clock and the reset.
module axi_stream_skid_slice #(
    parameter int COUNTS = 1
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [COUNTS-1:0]     s_axis_tvalid,
    input  logic [512*COUNTS-1:0] s_axis_tdata,
    input  logic [64*COUNTS-1:0]  s_axis_tkeep,
    input  logic [COUNTS-1:0]     s_axis_tlast,
    input  logic [16*COUNTS-1:0]  s_axis_tuser_size,
    input  logic [16*COUNTS-1:0]  s_axis_tuser_src,
    input  logic [16*COUNTS-1:0]  s_axis_tuser_dst,
    output logic [COUNTS-1:0]     s_axis_tready,
    output logic [COUNTS-1:0]     m_axis_tvalid,
    output logic [512*COUNTS-1:0] m_axis_tdata,
    output logic [64*COUNTS-1:0]  m_axis_tkeep,
    output logic [COUNTS-1:0]     m_axis_tlast,
    output logic [16*COUNTS-1:0]  m_axis_tuser_size,
    output logic [16*COUNTS-1:0]  m_axis_tuser_src,
    output logic [16*COUNTS-1:0]  m_axis_tuser_dst,
    input  logic [COUNTS-1:0]     m_axis_tready
);

    // One beat is {tdata, tkeep, tlast, tuser_size, tuser_src, tuser_dst}.
    localparam int BEAT_W = 512 + 64 + 1 + 16 * 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // main invalid
        ST_ONE   = 2'd1,   // main valid, skid empty
        ST_FULL  = 2'd2    // main and skid both valid
    } lane_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < COUNTS; gi++) begin : g_lane
            lane_state_t       state_reg;
            lane_state_t       state_next;
            logic              ready_reg;
            logic [BEAT_W-1:0] main_reg;
            logic [BEAT_W-1:0] skid_reg;
            logic [BEAT_W-1:0] in_beat;
            logic              up_xfer;
            logic              down_xfer;
            logic              load_main;
            logic              load_skid;
            logic              main_from_skid;

            assign in_beat = {s_axis_tdata[512*gi +: 512],
                              s_axis_tkeep[64*gi +: 64],
                              s_axis_tlast[gi],
                              s_axis_tuser_size[16*gi +: 16],
                              s_axis_tuser_src[16*gi +: 16],
                              s_axis_tuser_dst[16*gi +: 16]};

            // tready already excludes FULL and the reset-release cycle.
            assign up_xfer   = s_axis_tvalid[gi] & ready_reg;
            assign down_xfer = (state_reg != ST_EMPTY) & m_axis_tready[gi];

            // Next state and register-load strobes for the lane.
            always_comb begin
                state_next     = state_reg;
                load_main      = 1'b0;
                load_skid      = 1'b0;
                main_from_skid = 1'b0;
                case (state_reg)
                    ST_EMPTY: begin
                        if (up_xfer) begin
                            load_main  = 1'b1;
                            state_next = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (up_xfer && down_xfer) begin
                            load_main = 1'b1;
                        end else if (up_xfer) begin
                            load_skid  = 1'b1;
                            state_next = ST_FULL;
                        end else if (down_xfer) begin
                            state_next = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (down_xfer) begin
                            load_main      = 1'b1;
                            main_from_skid = 1'b1;
                            state_next     = ST_ONE;
                        end
                    end
                    default: begin
                        state_next = ST_EMPTY;
                    end
                endcase
            end

            // State and tready flops.
            // Reset clears them immediately; ready rises on the first edge after release.
            always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
                if (!axis_aresetn) begin
                    state_reg <= ST_EMPTY;
                    ready_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    ready_reg <= (state_next != ST_FULL);
                end
            end

            // Beat storage: data only, no reset.
            // Each register holds its value unless loaded.
            always_ff @(posedge axis_aclk) begin
                if (load_main) begin
                    main_reg <= main_from_skid ? skid_reg : in_beat;
                end
                if (load_skid) begin
                    skid_reg <= in_beat;
                end
            end

            assign s_axis_tready[gi] = ready_reg;
            assign m_axis_tvalid[gi] = (state_reg != ST_EMPTY);
            assign {m_axis_tdata[512*gi +: 512],
                    m_axis_tkeep[64*gi +: 64],
                    m_axis_tlast[gi],
                    m_axis_tuser_size[16*gi +: 16],
                    m_axis_tuser_src[16*gi +: 16],
                    m_axis_tuser_dst[16*gi +: 16]} = main_reg;
        end
    endgenerate

endmodule
